// File: rtl/io_ring_pkg.sv
// Shared encodings for the I/O ring sequencer: command modes and FSM states.
package io_ring_pkg;

    localparam logic [2:0] MODE_HOLD    = 3'd0;
    localparam logic [2:0] MODE_LOAD    = 3'd1;
    localparam logic [2:0] MODE_ROT_L   = 3'd2;
    localparam logic [2:0] MODE_ROT_R   = 3'd3;
    localparam logic [2:0] MODE_SHIFT_L = 3'd4;
    localparam logic [2:0] MODE_SHIFT_R = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ring_state_e;

    function automatic logic mode_reserved(input logic [2:0] mode);
        return mode > MODE_SHIFT_R;
    endfunction

endpackage

// File: rtl/io_ring_tick_gen.sv
// Clock-enable divider: tick is high for one cycle out of every CLK_DIV.
module io_ring_tick_gen
    import io_ring_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt;

    // With CLK_DIV == 1 the counter stays at zero and tick is constantly high.
    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/io_ring_seq.sv
// I/O ring sequencer: NUM_STAGES x DATA_W ring driven by load/rotate/shift commands,
// stepping at the rate of a clock-enable divider.
module io_ring_seq
    import io_ring_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int DATA_W     = 1,
    parameter int CLK_DIV    = 1,
    parameter int CNT_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_STAGES*DATA_W-1:0] io_in,
    output logic [NUM_STAGES*DATA_W-1:0] io_out,
    input  logic [DATA_W-1:0]            ser_in,
    output logic [DATA_W-1:0]            ser_out,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [2:0]                   cmd_mode,
    input  logic [CNT_W-1:0]             cmd_count,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic                         cmd_err
);

    localparam int RW = NUM_STAGES * DATA_W;

    ring_state_e       state_q, state_d;
    logic [RW-1:0]     ring_q, ring_d;
    logic [DATA_W-1:0] ser_q, ser_d;
    logic [CNT_W-1:0]  rem_q;
    logic [2:0]        mode_q;
    logic              err_q;
    logic              tick, div_clr, accept, step;

    function automatic logic [CNT_W-1:0] steps_for(input logic [2:0] mode,
                                                   input logic [CNT_W-1:0] count);
        case (mode)
            MODE_HOLD: return '0;
            MODE_LOAD: return CNT_W'(1);
            default:   return count;
        endcase
    endfunction

    // Divider only runs while a command is active, so the first step lands CLK_DIV cycles after accept.
    assign div_clr = (state_q != ST_RUN) || abort;

    io_ring_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (div_clr),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (!mode_reserved(cmd_mode)) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort wins over a coincident tick; a zero-step command leaves after one cycle.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (rem_q == '0) begin
                    state_d = ST_DONE;
                end else if (tick) begin
                    step = 1'b1;
                    if (rem_q == CNT_W'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ring_d = ring_q;
        ser_d  = ser_q;
        case (mode_q)
            MODE_LOAD: ring_d = io_in;
            MODE_ROT_L: begin
                for (int k = 0; k < NUM_STAGES; k++)
                    ring_d[k*DATA_W +: DATA_W] = ring_q[((k + NUM_STAGES - 1) % NUM_STAGES)*DATA_W +: DATA_W];
            end
            MODE_ROT_R: begin
                for (int k = 0; k < NUM_STAGES; k++)
                    ring_d[k*DATA_W +: DATA_W] = ring_q[((k + 1) % NUM_STAGES)*DATA_W +: DATA_W];
            end
            MODE_SHIFT_L: begin
                ring_d[0 +: DATA_W] = ser_in;
                for (int k = 1; k < NUM_STAGES; k++)
                    ring_d[k*DATA_W +: DATA_W] = ring_q[(k-1)*DATA_W +: DATA_W];
                ser_d = ring_q[(NUM_STAGES-1)*DATA_W +: DATA_W];
            end
            MODE_SHIFT_R: begin
                ring_d[(NUM_STAGES-1)*DATA_W +: DATA_W] = ser_in;
                for (int k = 0; k < NUM_STAGES - 1; k++)
                    ring_d[k*DATA_W +: DATA_W] = ring_q[(k+1)*DATA_W +: DATA_W];
                ser_d = ring_q[0 +: DATA_W];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ring_q <= '0;
            ser_q  <= '0;
            rem_q  <= '0;
            mode_q <= MODE_HOLD;
            err_q  <= 1'b0;
        end else begin
            err_q <= accept && mode_reserved(cmd_mode);
            if (accept) begin
                mode_q <= cmd_mode;
                rem_q  <= steps_for(cmd_mode, cmd_count);
            end
            if (step) begin
                ring_q <= ring_d;
                ser_q  <= ser_d;
                rem_q  <= rem_q - CNT_W'(1);
            end
        end
    end

    assign io_out    = ring_q;
    assign ser_out   = ser_q;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign cmd_err   = err_q;

endmodule

// File: tb/tb_io_ring_seq.sv
// Bench for io_ring_seq: two instances (CLK_DIV 1 and 3) checked cycle by cycle against a queue model.
module tb_io_ring_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] io_in     [2];
    logic [31:0] io_out    [2];
    logic [7:0]  ser_in    [2];
    logic [7:0]  ser_out   [2];
    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic [2:0]  cmd_mode  [2];
    logic [7:0]  cmd_count [2];
    logic        abort     [2];
    logic        busy      [2];
    logic        done      [2];
    logic        cmd_err   [2];

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mdl  [2][4];
    logic [7:0] mser [2];
    logic [7:0] ser_seq [$];

    always #5 clk = ~clk;

    io_ring_seq #(.NUM_STAGES(4), .DATA_W(8), .CLK_DIV(1), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .io_in(io_in[0]), .io_out(io_out[0]), .ser_in(ser_in[0]),
        .ser_out(ser_out[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_mode(cmd_mode[0]), .cmd_count(cmd_count[0]), .abort(abort[0]),
        .busy(busy[0]), .done(done[0]), .cmd_err(cmd_err[0]));

    io_ring_seq #(.NUM_STAGES(4), .DATA_W(8), .CLK_DIV(3), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .io_in(io_in[1]), .io_out(io_out[1]), .ser_in(ser_in[1]),
        .ser_out(ser_out[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_mode(cmd_mode[1]), .cmd_count(cmd_count[1]), .abort(abort[1]),
        .busy(busy[1]), .done(done[1]), .cmd_err(cmd_err[1]));

    function automatic logic [31:0] mdl_packed(input int d);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[k*8 +: 8] = mdl[d][k];
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) mdl[d][k] = 8'h00;
            mser[d] = 8'h00;
        end
    endtask

    // Ring as a queue, index 0 = stage 0.
    task automatic model_step(input int d, input logic [2:0] m, input logic [7:0] sin,
                              input logic [31:0] pin);
        logic [7:0] q [$];
        for (int k = 0; k < 4; k++) q.push_back(mdl[d][k]);
        case (m)
            3'd1: for (int k = 0; k < 4; k++) q[k] = pin[k*8 +: 8];
            3'd2: q.push_front(q.pop_back());
            3'd3: q.push_back(q.pop_front());
            3'd4: begin mser[d] = q.pop_back();  q.push_front(sin); end
            3'd5: begin mser[d] = q.pop_front(); q.push_back(sin);  end
            default: ;
        endcase
        for (int k = 0; k < 4; k++) mdl[d][k] = q[k];
    endtask

    task automatic check_outputs(input int d, input string tag, input logic exp_busy,
                                 input logic exp_done, input logic exp_rdy);
        n_chk++;
        if (io_out[d] !== mdl_packed(d) || ser_out[d] !== mser[d]) begin
            n_fail++;
            $display("FAIL %s dut%0d data: io_out=%h ser_out=%h expected io_out=%h ser_out=%h",
                     tag, d, io_out[d], ser_out[d], mdl_packed(d), mser[d]);
        end
        n_chk++;
        if (busy[d] !== exp_busy || done[d] !== exp_done || cmd_ready[d] !== exp_rdy || cmd_err[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s dut%0d ctrl: busy=%b done=%b ready=%b err=%b expected %b %b %b 0",
                     tag, d, busy[d], done[d], cmd_ready[d], cmd_err[d], exp_busy, exp_done, exp_rdy);
        end
    endtask

    // abort_at: -1 none, 0 random edge within the command, >0 that edge after accept.
    task automatic do_cmd(input int d, input logic [2:0] mode, input int count, input int abort_at,
                          input bit fix_io, input logic [31:0] fix_val, output int done_edge);
        int w, div, steps, last, rem, ab_edge, valid_until;
        bit ab, aborted;
        done_edge = -1;
        div = (d == 0) ? 1 : 3;
        w = 0;
        while (cmd_ready[d] !== 1'b1 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (cmd_ready[d] !== 1'b1) begin
            n_chk++; n_fail++;
            $display("FAIL ready_wait dut%0d: ready=%b expected 1 within 50 cycles", d, cmd_ready[d]);
            return;
        end
        cmd_valid[d] = 1'b1; cmd_mode[d] = mode; cmd_count[d] = 8'(count); abort[d] = 1'b0;
        io_in[d] = $urandom; ser_in[d] = 8'($urandom);
        @(posedge clk); #1;
        if (mode > 3'd5) begin
            cmd_valid[d] = 1'b0;
            n_chk++;
            if (cmd_err[d] !== 1'b1 || cmd_ready[d] !== 1'b1 || busy[d] !== 1'b0 || io_out[d] !== mdl_packed(d)) begin
                n_fail++;
                $display("FAIL reserved dut%0d: err=%b ready=%b busy=%b io_out=%h expected 1 1 0 %h",
                         d, cmd_err[d], cmd_ready[d], busy[d], io_out[d], mdl_packed(d));
            end
            @(posedge clk); #1;
            n_chk++;
            if (cmd_err[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reserved_pulse dut%0d: err=%b expected 0", d, cmd_err[d]);
            end
            return;
        end
        steps = (mode == 3'd0) ? 0 : (mode == 3'd1) ? 1 : count;
        last  = (steps == 0) ? 1 : steps * div;
        rem   = steps;
        ab_edge = (abort_at == 0) ? int'($urandom_range(1, last)) : abort_at;
        valid_until = (ab_edge > 0) ? ab_edge : last + 1;
        aborted = 1'b0;
        for (int c = 1; c <= last + 1; c++) begin
            ab = (ab_edge == c);
            abort[d] = ab ? 1'b1 : ((ab_edge < 0 && c == last + 1) ? 1'($urandom) : 1'b0);
            cmd_valid[d] = (c <= valid_until) ? 1'($urandom) : 1'b0;
            cmd_mode[d]  = 3'($urandom);
            cmd_count[d] = 8'($urandom);
            io_in[d]  = fix_io ? fix_val : $urandom;
            ser_in[d] = (ser_seq.size() > 0) ? ser_seq.pop_front() : 8'($urandom);
            @(posedge clk);
            if (ab) aborted = 1'b1;
            else if (rem > 0 && (c % div) == 0) begin
                model_step(d, mode, ser_in[d], io_in[d]);
                rem--;
            end
            #1;
            if (aborted) begin
                check_outputs(d, "abort", 1'b0, 1'b0, 1'b1);
                break;
            end else if (c < last) begin
                check_outputs(d, "run", 1'b1, 1'b0, 1'b0);
            end else if (c == last) begin
                check_outputs(d, "done", 1'b0, 1'b1, 1'b0);
                done_edge = c;
            end else begin
                check_outputs(d, "idle", 1'b0, 1'b0, 1'b1);
            end
        end
        cmd_valid[d] = 1'b0;
        abort[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        for (int d = 0; d < 2; d++) check_outputs(d, "reset", 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
    endtask

    task automatic test_load();
        int de;
        do_cmd(0, 3'd1, 9, -1, 1'b1, 32'h44332211, de);
        n_chk++;
        if (io_out[0] !== 32'h44332211 || de != 1) begin
            n_fail++;
            $display("FAIL load: io_out=%h done_edge=%0d expected 44332211 1", io_out[0], de);
        end
    endtask

    task automatic test_rotate();
        int de;
        do_cmd(0, 3'd2, 1, -1, 1'b0, 32'h0, de);
        n_chk++;
        if (io_out[0] !== 32'h33221144) begin
            n_fail++;
            $display("FAIL rot_l: io_out=%h expected 33221144", io_out[0]);
        end
        do_cmd(0, 3'd1, 0, -1, 1'b1, 32'h44332211, de);
        do_cmd(0, 3'd3, 4, -1, 1'b0, 32'h0, de);
        n_chk++;
        if (io_out[0] !== 32'h44332211) begin
            n_fail++;
            $display("FAIL rot_r4: io_out=%h expected 44332211", io_out[0]);
        end
    endtask

    task automatic test_shift();
        int de;
        do_cmd(0, 3'd1, 0, -1, 1'b1, 32'h44332211, de);
        ser_seq.push_back(8'hAA);
        ser_seq.push_back(8'hBB);
        do_cmd(0, 3'd4, 2, -1, 1'b0, 32'h0, de);
        n_chk++;
        if (io_out[0] !== 32'h2211AABB || ser_out[0] !== 8'h33) begin
            n_fail++;
            $display("FAIL shift_l: io_out=%h ser_out=%h expected 2211aabb 33", io_out[0], ser_out[0]);
        end
        do_cmd(0, 3'd5, 3, -1, 1'b0, 32'h0, de);
        do_cmd(1, 3'd5, 2, -1, 1'b0, 32'h0, de);
    endtask

    task automatic test_divider();
        int de;
        do_cmd(1, 3'd1, 0, -1, 1'b1, 32'h44332211, de);
        n_chk++;
        if (de != 3) begin
            n_fail++;
            $display("FAIL div_load: done_edge=%0d expected 3", de);
        end
        do_cmd(1, 3'd2, 2, -1, 1'b0, 32'h0, de);
        n_chk++;
        if (de != 6 || io_out[1] !== 32'h22114433) begin
            n_fail++;
            $display("FAIL div_rot: done_edge=%0d io_out=%h expected 6 22114433", de, io_out[1]);
        end
    endtask

    task automatic test_abort();
        int de;
        do_cmd(0, 3'd1, 0, -1, 1'b1, 32'h44332211, de);
        do_cmd(0, 3'd2, 5, 2, 1'b0, 32'h0, de);
        n_chk++;
        if (io_out[0] !== 32'h33221144 || de != -1) begin
            n_fail++;
            $display("FAIL abort0: io_out=%h done_edge=%0d expected 33221144 -1", io_out[0], de);
        end
        do_cmd(1, 3'd1, 0, -1, 1'b1, 32'h44332211, de);
        do_cmd(1, 3'd2, 5, 6, 1'b0, 32'h0, de);
        n_chk++;
        if (io_out[1] !== 32'h33221144) begin
            n_fail++;
            $display("FAIL abort1: io_out=%h expected 33221144", io_out[1]);
        end
    endtask

    task automatic test_reserved_and_zero();
        int de;
        do_cmd(0, 3'd7, 3, -1, 1'b0, 32'h0, de);
        do_cmd(1, 3'd6, 3, -1, 1'b0, 32'h0, de);
        do_cmd(0, 3'd0, 7, -1, 1'b0, 32'h0, de);
        do_cmd(1, 3'd2, 0, -1, 1'b0, 32'h0, de);
        do_cmd(1, 3'd5, 0, -1, 1'b0, 32'h0, de);
    endtask

    task automatic test_back_to_back();
        int de;
        for (int i = 0; i < 40; i++) begin
            for (int d = 0; d < 2; d++) begin
                do_cmd(d, 3'($urandom), int'($urandom_range(0, 6)),
                       ($urandom_range(0, 3) == 0) ? 0 : -1, 1'b0, 32'h0, de);
            end
        end
    endtask

    task automatic test_rst_mid_run();
        int de;
        do_cmd(0, 3'd1, 0, -1, 1'b0, 32'h0, de);
        cmd_valid[0] = 1'b1; cmd_mode[0] = 3'd2; cmd_count[0] = 8'd10;
        @(posedge clk); #1;
        cmd_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        abort[0] = 1'b1;
        @(posedge clk); #1;
        model_reset();
        check_outputs(0, "rst_mid_run", 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        abort[0] = 1'b0;
        do_cmd(0, 3'd3, 2, -1, 1'b0, 32'h0, de);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            io_in[d] = '0; ser_in[d] = '0; cmd_valid[d] = 1'b0;
            cmd_mode[d] = '0; cmd_count[d] = '0; abort[d] = 1'b0;
        end
        test_reset();
        test_load();
        test_rotate();
        test_shift();
        test_divider();
        test_abort();
        test_reserved_and_zero();
        test_back_to_back();
        test_rst_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
